adc_tone_meter: RTL

- Receive-side companion to the NCO/DAC sine generator: captures ADC samples of the analog tone and measures its frequency.
- Uses hysteretic rising zero-crossing detection and a fixed gate window.
- Reports crossing count, last period in clocks, and the estimated 4-bit step setting that produced the tone (step = sw << 22 on a 32-bit phase accumulator).
- Sits between the ADC capture pins and the status/readout logic.

---
 rtl/nco_pkg.sv | 21 ++
 rtl/zero_cross_det.sv | 44 ++++
 rtl/adc_tone_meter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Definitions shared between the NCO/DAC tone generator and the ADC tone meter.
package nco_pkg;
   localparam int PHASE_W    = 32;
   localparam int STEP_SHIFT = 22;
   localparam int DAC_W      = 14;

   typedef enum logic [1:0] {WAIT_LOCK, GATE, REPORT} meter_state_t;
   typedef enum logic {NEG, POS} level_t;

   // Offset binary to two's complement: flip the MSB.
   function automatic logic signed [DAC_W-1:0] ob_to_signed(input logic [DAC_W-1:0] s);
      return {~s[DAC_W-1], s[DAC_W-2:0]};
   endfunction

   // Nominal count per gate is 16*sw, so round count/16 to the nearest step.
   function automatic logic [3:0] sw_from_count(input logic [15:0] c);
      logic [16:0] r;
      r = ({1'b0, c} + 17'd8) >> 4;
      return (r > 17'd15) ? 4'd15 : r[3:0];
   endfunction
endpackage

// File: rtl/zero_cross_det.sv
// Registered ADC input stage with a hysteretic rising zero-crossing detector.
module zero_cross_det
   import nco_pkg::*;
#(
   parameter int DATA_W = DAC_W,
   parameter int HYST   = 256
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   output logic              rise
);
   localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
   localparam logic signed [DATA_W-1:0] HYST_NEG = -HYST_POS;

   logic [DATA_W-1:0]        data_q;
   logic                     valid_q;
   level_t                   level;
   logic signed [DATA_W-1:0] sample;

   assign sample = ob_to_signed(data_q);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         level   <= NEG;
         rise    <= 1'b0;
      end else begin
         data_q  <= adc_data;
         valid_q <= adc_valid;
         rise    <= 1'b0;
         if (valid_q) begin
            if (level == NEG && sample >= HYST_POS) begin
               level <= POS;
               rise  <= 1'b1;
            end else if (level == POS && sample <= HYST_NEG) begin
               level <= NEG;
            end
         end
      end
   end
endmodule

// File: rtl/adc_tone_meter.sv
// Measures the frequency of the NCO tone seen on the ADC: gated crossing count,
// last period in clocks, and the estimated NCO step setting.
//
// state     | meaning
// WAIT_LOCK | waiting for an aligning rising crossing
// GATE      | counting crossings inside the gate window
// REPORT    | publish results; first cycle of the next window
module adc_tone_meter
   import nco_pkg::*;
#(
   parameter int DATA_W      = DAC_W,
   parameter int HYST        = 256,
   parameter int GATE_CYCLES = 16384,
   parameter int PER_W       = 16,
   parameter int TIMEOUT     = 65535
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   output logic              o_clk_to_adc,
   output logic [15:0]       cross_count,
   output logic [PER_W-1:0]  period,
   output logic [3:0]        sw_est,
   output logic              no_signal,
   output logic              meas_valid
);
   localparam int GATE_W = $clog2(GATE_CYCLES);
   localparam int TO_W   = $clog2(TIMEOUT + 1);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [PER_W-1:0]  PER_MAX   = '1;
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0]   TO_SAT    = TO_W'(TIMEOUT);

   logic              rise;
   logic              timeout_hit;
   logic              have_ref;
   meter_state_t      state;
   logic [GATE_W-1:0] gate_cnt;
   logic [15:0]       count;
   logic [PER_W-1:0]  per_cnt;
   logic [TO_W-1:0]   to_cnt;

   assign o_clk_to_adc = ~i_clk;

   zero_cross_det #(
      .DATA_W (DATA_W),
      .HYST   (HYST)
   ) u_zcd (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .adc_data  (adc_data),
      .adc_valid (adc_valid),
      .rise      (rise)
   );

   // The timeout counter parks at TIMEOUT so the timeout report fires only once.
   assign timeout_hit = !rise && (to_cnt == TO_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= WAIT_LOCK;
         gate_cnt    <= '0;
         count       <= '0;
         per_cnt     <= '0;
         to_cnt      <= '0;
         have_ref    <= 1'b0;
         cross_count <= '0;
         period      <= '0;
         sw_est      <= '0;
         no_signal   <= 1'b0;
         meas_valid  <= 1'b0;
      end else begin
         meas_valid <= 1'b0;

         if (rise) begin
            per_cnt  <= '0;
            have_ref <= 1'b1;
            if (have_ref)
               period <= (per_cnt == PER_MAX) ? PER_MAX : per_cnt + PER_W'(1);
         end else if (per_cnt != PER_MAX) begin
            per_cnt <= per_cnt + PER_W'(1);
         end

         if (rise)
            to_cnt <= '0;
         else if (to_cnt != TO_SAT)
            to_cnt <= to_cnt + TO_W'(1);

         if (rise)
            no_signal <= 1'b0;
         else if (timeout_hit) begin
            no_signal <= 1'b1;
            have_ref  <= 1'b0;
         end

         if (timeout_hit) begin
            state       <= WAIT_LOCK;
            count       <= '0;
            cross_count <= '0;
            sw_est      <= '0;
            meas_valid  <= 1'b1;
         end else begin
            case (state)
               WAIT_LOCK: begin
                  if (rise) begin
                     gate_cnt <= '0;
                     count    <= '0;
                     state    <= GATE;
                  end
               end
               GATE: begin
                  if (rise && count != 16'hFFFF)
                     count <= count + 16'd1;
                  if (gate_cnt == GATE_LAST)
                     state <= REPORT;
                  else
                     gate_cnt <= gate_cnt + GATE_W'(1);
               end
               REPORT: begin
                  cross_count <= count;
                  sw_est      <= sw_from_count(count);
                  meas_valid  <= 1'b1;
                  count       <= rise ? 16'd1 : 16'd0;
                  gate_cnt    <= GATE_W'(1);
                  state       <= GATE;
               end
               default: state <= WAIT_LOCK;
            endcase
         end
      end
   end
endmodule
